scene_sequencer: RTL and testbench
==================================

// Module: scene_sequencer
// PURPOSE
//  Top-level game-flow controller: sequences MENU -> COUNTDOWN -> RACE -> RESULT -> MENU.
//  Sits beside the menu and race video pipelines and drives the scene select of the final RGB mux.
//  Generates the pipeline reset pulses and the race enable. Changes scene only at frame boundaries,
//  so no frame is ever torn.
// PARAMETERS
//  COUNT_FRAMES   60   frames per countdown digit (3,2,1)
//  RESULT_FRAMES  300  frames the RESULT scene is held before auto-return to MENU
//  CNT_W          9    width of the frame counter; must hold max(COUNT_FRAMES, RESULT_FRAMES)
// PORTS
//  clk              in   1  pixel clock
//  rst              in   1  synchronous, active-high reset
//  vblnk_in         in   1  vertical blank from the timing generator
//  start_game_flag  in   1  1-cycle pulse from the menu, asynchronous to the frame
//  race_finished    in   1  1-cycle pulse from the race logic
//  winner_in        in   1  winner id; sampled together with race_finished
//  keyboard_in      in   4  [0] enter, [1] up, [2] down, [3] esc; level, synchronous to clk
//  scene            out  3  0 MENU, 1 COUNTDOWN, 2 RACE, 3 RESULT, 4 PAUSE
//  race_en          out  1  high only while scene == RACE
//  countdown_value  out  2  3,2,1 during COUNTDOWN; 0 otherwise
//  menu_rst         out  1  1-cycle pulse on entry to MENU
//  race_rst         out  1  1-cycle pulse on entry to COUNTDOWN
//  winner_out       out  1  latched winner; valid in RESULT
// BEHAVIOUR
//  - frame_tick: 1-cycle pulse on the 0->1 edge of vblnk_in (previous vblnk_in registered).
//  - Reset values: scene=0, race_en=0, countdown_value=0, menu_rst=0, race_rst=0, winner_out=0,
//    frame counter=0, all pending flags=0.
//  - rst asserted at any time forces MENU on the next edge. No menu_rst pulse is generated
//    on reset exit.
//  - Event capture:
//    - start_game_flag sets start_pend; race_finished sets fin_pend and latches winner_in.
//    - keyboard_in[0] rising edge sets enter_pend.
//    - All pending flags clear on every frame_tick, whether the event was consumed or not.
//      Events irrelevant to the current state are therefore dropped.
//  - Transitions are evaluated only on frame_tick. scene/race_en/countdown_value update in the
//    same cycle as the state register (registered outputs, 1-cycle latency from frame_tick).
//  - MENU:
//    - start_pend -> COUNTDOWN: counter=0, countdown_value=3, race_rst pulse.
//  - COUNTDOWN:
//    - counter increments per tick.
//    - At counter==COUNT_FRAMES-1: counter=0, countdown_value decrements.
//    - When the value would reach 0 -> RACE, race_en=1.
//  - RACE:
//    - fin_pend -> RESULT: race_en=0, counter=0, winner_out = latched winner.
//  - RESULT:
//    - Return to MENU (menu_rst pulse) on enter_pend or counter==RESULT_FRAMES-1, whichever first.
//    - winner_out holds until the next RESULT entry.
//  - Simultaneous events in one frame: only the event relevant to the current state acts.
//    start_pend in RACE or fin_pend in MENU is discarded.
//  - Counter never wraps: it resets on every state entry and is compared with ==.
//  - menu_rst and race_rst are high for exactly one clk cycle, never both in the same cycle.
// CONFIGURATION
//  PAUSE_EN defined:
//    - keyboard_in[3] rising edge sets esc_pend.
//    - On a tick, RACE + esc_pend -> PAUSE (scene=4, race_en=0); PAUSE + esc_pend -> RACE (race_en=1).
//    - fin_pend in PAUSE is latched and held (not cleared by ticks) until the return to RACE,
//      then acted on at the next tick.
//  PAUSE_EN undefined:
//    - keyboard_in[3] is ignored; scene encoding 4 is never produced.
// STRUCTURE
//  - Shared package scene_pkg: scene encodings (SCN_MENU..SCN_PAUSE), key bit indices
//    (KEY_ENTER, KEY_UP, KEY_DOWN, KEY_ESC), and the scene width constant.
//  - One sub-module: frame_tick_gen (vblnk edge detector, clk/rst, 1-cycle tick output).
//  - Everything else is one FSM with registered outputs.
// TESTING
//  (Bench uses COUNT_FRAMES=2, RESULT_FRAMES=4.)
//  1 Reset, then start_game_flag mid-frame -> COUNTDOWN at the next tick with race_rst high one
//    cycle; value 3,3,2,2,1,1 over ticks; RACE with race_en=1 on the 7th tick.
//  2 In RACE, race_finished with winner_in=1 -> RESULT at the next tick, winner_out=1,
//    race_en=0; MENU with menu_rst pulse after 4 ticks.
//  3 In RESULT, enter rising edge at tick 1 -> MENU at tick 2 (before the timeout).
//  4 In MENU, race_finished -> ignored, scene stays 0. In RACE, start_game_flag -> ignored.
//  5 rst asserted mid-COUNTDOWN -> next cycle scene=0 and countdown_value=0; no pulses generated.
//  6 PAUSE_EN defined: esc in RACE -> scene=4 and race_en=0; race_finished while paused, then
//    esc -> RACE, then RESULT one tick later. Undefined: esc has no effect.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared scene encodings and keyboard bit positions for the game-flow controller.
package scene_pkg;

  localparam int SCN_W = 3;

  typedef enum logic [SCN_W-1:0] {
    SCN_MENU      = 3'd0,
    SCN_COUNTDOWN = 3'd1,
    SCN_RACE      = 3'd2,
    SCN_RESULT    = 3'd3,
    SCN_PAUSE     = 3'd4
  } scene_e;

  localparam int KEY_ENTER = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_ESC   = 3;

endpackage

// File: rtl/scene_sequencer_frame_tick_gen.sv
// Frame boundary detector: one-cycle tick on the rising edge of vertical blank.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic i_vblnk,
  output logic o_tick
);

  logic r_vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) r_vblnk_d <= 1'b0;
    else     r_vblnk_d <= i_vblnk;
  end

  assign o_tick = i_vblnk & ~r_vblnk_d;

endmodule

// File: rtl/scene_sequencer.sv
// Game-flow FSM (MENU -> COUNTDOWN -> RACE -> RESULT) switching scenes only on frame ticks.
// Optional PAUSE scene enabled by defining PAUSE_EN.
//
// state          | meaning
// SCN_MENU       | menu pipeline shown, waiting for start
// SCN_COUNTDOWN  | 3,2,1 countdown, COUNT_FRAMES frames per digit
// SCN_RACE       | race running, race_en high
// SCN_RESULT     | winner shown, held RESULT_FRAMES frames or until enter
// SCN_PAUSE      | race frozen (PAUSE_EN builds only)
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int COUNT_FRAMES  = 60,
  parameter int RESULT_FRAMES = 300,
  parameter int CNT_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic             start_game_flag,
  input  logic             race_finished,
  input  logic             winner_in,
  input  logic [3:0]       keyboard_in,
  output logic [SCN_W-1:0] scene,
  output logic             race_en,
  output logic [1:0]       countdown_value,
  output logic             menu_rst,
  output logic             race_rst,
  output logic             winner_out
);

  logic w_tick;

  frame_tick_gen u_frame_tick (
    .clk     (clk),
    .rst     (rst),
    .i_vblnk (vblnk_in),
    .o_tick  (w_tick)
  );

  scene_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_cd_val, w_cd_nxt;
  logic             r_race_en, r_menu_rst, r_race_rst, r_winner_out;
  logic             w_race_en_nxt, w_menu_rst_nxt, w_race_rst_nxt, w_winner_nxt;
  logic             r_start_pend, r_fin_pend, r_enter_pend;
  logic             r_winner_lat, r_enter_d;
  logic             w_enter_rise, w_fin_hold;

  assign w_enter_rise = keyboard_in[KEY_ENTER] & ~r_enter_d;

`ifdef PAUSE_EN
  logic r_esc_d, r_esc_pend, w_esc_rise;
  logic w_unused_keys;
  assign w_unused_keys = keyboard_in[KEY_UP] ^ keyboard_in[KEY_DOWN];
  assign w_esc_rise    = keyboard_in[KEY_ESC] & ~r_esc_d;
  // A finish arriving while paused must survive until the race resumes.
  assign w_fin_hold    = (r_state == SCN_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_esc_d    <= 1'b0;
      r_esc_pend <= 1'b0;
    end else begin
      r_esc_d    <= keyboard_in[KEY_ESC];
      r_esc_pend <= w_esc_rise | (r_esc_pend & ~w_tick);
    end
  end
`else
  logic w_unused_keys;
  assign w_unused_keys = ^keyboard_in[KEY_ESC:KEY_UP];
  assign w_fin_hold    = 1'b0;
`endif

  // Set wins over the tick clear so an event coinciding with a tick lands in the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_pend <= 1'b0;
      r_fin_pend   <= 1'b0;
      r_enter_pend <= 1'b0;
      r_winner_lat <= 1'b0;
      r_enter_d    <= 1'b0;
    end else begin
      r_enter_d    <= keyboard_in[KEY_ENTER];
      r_start_pend <= start_game_flag | (r_start_pend & ~w_tick);
      r_fin_pend   <= race_finished | (r_fin_pend & ~(w_tick & ~w_fin_hold));
      r_enter_pend <= w_enter_rise | (r_enter_pend & ~w_tick);
      if (race_finished) r_winner_lat <= winner_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SCN_MENU;
      r_cnt        <= '0;
      r_cd_val     <= 2'd0;
      r_race_en    <= 1'b0;
      r_menu_rst   <= 1'b0;
      r_race_rst   <= 1'b0;
      r_winner_out <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cd_val     <= w_cd_nxt;
      r_race_en    <= w_race_en_nxt;
      r_menu_rst   <= w_menu_rst_nxt;
      r_race_rst   <= w_race_rst_nxt;
      r_winner_out <= w_winner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cd_nxt    = r_cd_val;
    if (w_tick) begin
      case (r_state)
        SCN_MENU: begin
          if (r_start_pend) begin
            w_state_nxt = SCN_COUNTDOWN;
            w_cnt_nxt   = '0;
            w_cd_nxt    = 2'd3;
          end
        end
        SCN_COUNTDOWN: begin
          if (r_cnt == CNT_W'(COUNT_FRAMES - 1)) begin
            w_cnt_nxt = '0;
            if (r_cd_val == 2'd1) begin
              w_state_nxt = SCN_RACE;
              w_cd_nxt    = 2'd0;
            end else begin
              w_cd_nxt = r_cd_val - 2'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        SCN_RACE: begin
          if (r_fin_pend) begin
            w_state_nxt = SCN_RESULT;
            w_cnt_nxt   = '0;
          end
`ifdef PAUSE_EN
          else if (r_esc_pend) begin
            w_state_nxt = SCN_PAUSE;
          end
`endif
        end
        SCN_RESULT: begin
          if (r_enter_pend || (r_cnt == CNT_W'(RESULT_FRAMES - 1))) begin
            w_state_nxt = SCN_MENU;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`ifdef PAUSE_EN
        SCN_PAUSE: begin
          if (r_esc_pend) w_state_nxt = SCN_RACE;
        end
`endif
        default: begin
          w_state_nxt = SCN_MENU;
          w_cnt_nxt   = '0;
          w_cd_nxt    = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_race_en_nxt  = (w_state_nxt == SCN_RACE);
    w_menu_rst_nxt = (w_state_nxt == SCN_MENU) && (r_state != SCN_MENU);
    w_race_rst_nxt = (w_state_nxt == SCN_COUNTDOWN) && (r_state != SCN_COUNTDOWN);
    w_winner_nxt   = r_winner_out;
    if ((w_state_nxt == SCN_RESULT) && (r_state != SCN_RESULT)) w_winner_nxt = r_winner_lat;
  end

  assign scene           = r_state;
  assign race_en         = r_race_en;
  assign countdown_value = r_cd_val;
  assign menu_rst        = r_menu_rst;
  assign race_rst        = r_race_rst;
  assign winner_out      = r_winner_out;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: frame-level model plus directed scenarios.
// Build with PAUSE_EN defined to exercise the pause scene.
module tb_scene_sequencer;

  localparam int CF     = 2;
  localparam int RF     = 4;
  localparam int FRAME  = 20;
  localparam int VB_LEN = 4;
`ifdef PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic       start_game_flag;
  logic       race_finished;
  logic       winner_in;
  logic [3:0] keyboard_in;
  logic [2:0] scene;
  logic       race_en;
  logic [1:0] countdown_value;
  logic       menu_rst;
  logic       race_rst;
  logic       winner_out;

  scene_sequencer #(
    .COUNT_FRAMES  (CF),
    .RESULT_FRAMES (RF),
    .CNT_W         (9)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vblnk_in        (vblnk_in),
    .start_game_flag (start_game_flag),
    .race_finished   (race_finished),
    .winner_in       (winner_in),
    .keyboard_in     (keyboard_in),
    .scene           (scene),
    .race_en         (race_en),
    .countdown_value (countdown_value),
    .menu_rst        (menu_rst),
    .race_rst        (race_rst),
    .winner_out      (winner_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vblnk_in = 1'b0;
    forever begin
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        vblnk_in = (i < VB_LEN);
      end
    end
  end

  // Frame-level model: scene plus frames spent in it; outputs derived from those.
  int m_scene, m_frames, tick_count;
  bit m_start_p, m_fin_p, m_enter_p, m_esc_p, m_wlat;
  bit m_vb_prev, m_ent_prev, m_esc_prev;
  bit m_menu_rst, m_race_rst, m_winner;

  always @(posedge clk) begin
    bit tick, was_pause;
    if (rst) begin
      m_scene = 0; m_frames = 0;
      m_start_p = 0; m_fin_p = 0; m_enter_p = 0; m_esc_p = 0; m_wlat = 0;
      m_vb_prev = 0; m_ent_prev = 0; m_esc_prev = 0;
      m_menu_rst = 0; m_race_rst = 0; m_winner = 0;
    end else begin
      tick = vblnk_in && !m_vb_prev;
      m_vb_prev = vblnk_in;
      m_menu_rst = 0;
      m_race_rst = 0;
      if (tick) begin
        tick_count++;
        was_pause = (m_scene == 4);
        case (m_scene)
          0: if (m_start_p) begin m_scene = 1; m_frames = 0; m_race_rst = 1; end
          1: begin m_frames++; if (m_frames == 3 * CF) m_scene = 2; end
          2: begin
            if (m_fin_p) begin m_scene = 3; m_frames = 0; m_winner = m_wlat; end
            else if (PAUSE && m_esc_p) m_scene = 4;
          end
          3: begin
            m_frames++;
            if (m_enter_p || m_frames == RF) begin m_scene = 0; m_menu_rst = 1; end
          end
          4: if (m_esc_p) m_scene = 2;
          default: m_scene = 0;
        endcase
        m_start_p = 0; m_enter_p = 0; m_esc_p = 0;
        if (!was_pause) m_fin_p = 0;
      end
      if (start_game_flag) m_start_p = 1;
      if (race_finished) begin m_fin_p = 1; m_wlat = winner_in; end
      if (keyboard_in[0] && !m_ent_prev) m_enter_p = 1;
      m_ent_prev = keyboard_in[0];
      if (PAUSE && keyboard_in[3] && !m_esc_prev) m_esc_p = 1;
      m_esc_prev = keyboard_in[3];
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("scene", scene, m_scene);
      chk("race_en", race_en, (m_scene == 2));
      chk("countdown_value", countdown_value, (m_scene == 1) ? (3 - m_frames / CF) : 0);
      chk("menu_rst", menu_rst, m_menu_rst);
      chk("race_rst", race_rst, m_race_rst);
      chk("winner_out", winner_out, m_winner);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = tick_count + n;
    budget = n * FRAME + 10;
    while (tick_count < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (tick_count < target) begin
      checks++;
      errors++;
      $display("FAIL tick_wait: got %0d ticks expected %0d", tick_count, target);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start_game_flag = 1'b1;
    @(negedge clk); start_game_flag = 1'b0;
  endtask

  task automatic pulse_fin(input bit w);
    @(negedge clk); race_finished = 1'b1; winner_in = w;
    @(negedge clk); race_finished = 1'b0; winner_in = 1'b0;
  endtask

  task automatic press_key(input int idx);
    @(negedge clk); keyboard_in[idx] = 1'b1;
    idle(3);
    keyboard_in[idx] = 1'b0;
  endtask

  initial begin
    int exp_cd[5];
    exp_cd = '{3, 2, 2, 1, 1};
    rst = 1'b1; start_game_flag = 1'b0; race_finished = 1'b0;
    winner_in = 1'b0; keyboard_in = 4'h0;
    @(negedge clk);
    cmp_en = 1'b1;
    idle(2);
    chk("rst_scene", scene, 0);
    chk("rst_countdown", countdown_value, 0);
    chk("rst_winner", winner_out, 0);
    rst = 1'b0;

    // 1: start mid-frame, countdown digits, then race
    wait_ticks(1); idle(3); pulse_start();
    wait_ticks(1);
    chk("t1_scene_cd", scene, 1);
    chk("t1_race_rst", race_rst, 1);
    chk("t1_cd3", countdown_value, 3);
    idle(1);
    chk("t1_race_rst_one_cycle", race_rst, 0);
    for (int i = 0; i < 5; i++) begin
      wait_ticks(1);
      chk("t1_cd_seq", countdown_value, exp_cd[i]);
    end
    wait_ticks(1);
    chk("t1_scene_race", scene, 2);
    chk("t1_race_en", race_en, 1);
    chk("t1_cd0", countdown_value, 0);

    // 4b: start ignored in race
    idle(3); pulse_start(); wait_ticks(1);
    chk("t4_start_in_race", scene, 2);

    // 2: finish with winner 1, result timeout
    idle(3); pulse_fin(1'b1); wait_ticks(1);
    chk("t2_scene_result", scene, 3);
    chk("t2_winner", winner_out, 1);
    chk("t2_race_en_off", race_en, 0);
    wait_ticks(3);
    chk("t2_still_result", scene, 3);
    wait_ticks(1);
    chk("t2_scene_menu", scene, 0);
    chk("t2_menu_rst", menu_rst, 1);
    chk("t2_winner_hold", winner_out, 1);

    // 4a: finish ignored in menu
    idle(3); pulse_fin(1'b0); wait_ticks(1);
    chk("t4_fin_in_menu", scene, 0);
    chk("t4_winner_kept", winner_out, 1);

    // 3: enter in result returns early
    idle(3); pulse_start(); wait_ticks(7);
    chk("t3_race", scene, 2);
    idle(3); pulse_fin(1'b0); wait_ticks(1);
    chk("t3_result", scene, 3);
    chk("t3_winner0", winner_out, 0);
    wait_ticks(1); idle(3); press_key(0); wait_ticks(1);
    chk("t3_enter_menu", scene, 0);
    chk("t3_menu_rst", menu_rst, 1);

    // 6: esc in race
    idle(3); pulse_start(); wait_ticks(7);
    idle(3); press_key(3); wait_ticks(1);
`ifdef PAUSE_EN
    chk("t6_paused", scene, 4);
    chk("t6_race_en_off", race_en, 0);
    idle(3); pulse_fin(1'b1); wait_ticks(1);
    chk("t6_fin_held", scene, 4);
    idle(3); press_key(3); wait_ticks(1);
    chk("t6_resume", scene, 2);
    chk("t6_race_en_on", race_en, 1);
    wait_ticks(1);
    chk("t6_result", scene, 3);
    chk("t6_winner", winner_out, 1);
`else
    chk("t6_esc_ignored", scene, 2);
    chk("t6_race_en_on", race_en, 1);
    idle(3); pulse_fin(1'b1); wait_ticks(1);
    chk("t6_result", scene, 3);
    chk("t6_winner", winner_out, 1);
`endif
    wait_ticks(4);
    chk("t6_back_menu", scene, 0);

    // 5: reset mid-countdown
    idle(3); pulse_start(); wait_ticks(3);
    chk("t5_in_cd", scene, 1);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_scene", scene, 0);
    chk("t5_cd", countdown_value, 0);
    chk("t5_menu_rst", menu_rst, 0);
    chk("t5_race_rst", race_rst, 0);
    rst = 1'b0;
    wait_ticks(2);
    chk("t5_stay_menu", scene, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
